// File: rtl/uart_pkg.sv
// Shared UART definitions.
//
// Holds the transmitter state encoding, the default bit-time counter width and
// a frame-length helper that the transmitter and a future receiver both use.
// There are no ports; other files import this with import uart_pkg::*.
//
// ST_PARITY is part of the encoding in every build. The transmitter only
// enters it when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_e;

  localparam int unsigned UART_DEF_CLKS_PER_BIT = 16;

  // Width of a counter that spans 0..clks_per_bit-1 (never narrower than 1 bit).
  function automatic int unsigned baud_cnt_w(input int unsigned clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

  localparam int unsigned UART_BAUD_CNT_W = baud_cnt_w(UART_DEF_CLKS_PER_BIT);

  // Clock cycles per frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_len(input int unsigned clks_per_bit,
                                            input int unsigned data_w,
                                            input int unsigned parity_bits,
                                            input int unsigned stop_bits);
    return clks_per_bit * (1 + data_w + parity_bits + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-time counter.
//
// The counter runs 0..CLKS_PER_BIT-1 and wraps. tick_o is high for the single
// cycle in which the count is CLKS_PER_BIT-1, which is the last cycle of a bit
// time. clr_i restarts the count at 0 on the next edge, so a new frame is
// aligned to its pop.
//
// Ports:
//   clk_i   in   clock
//   rst_ni  in   synchronous active-low reset
//   clr_i   in   synchronous clear
//   tick_o  out  last cycle of the current bit time
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned         CNT_W    = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick_o = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a show-ahead FIFO.
//
// When the FIFO holds a word and the line is free, the block pops that word
// and sends it LSB-first. The frame is one start bit, DATA_W data bits, an
// optional even-parity bit and STOP_BITS stop bits. If another word is ready
// on the last cycle of the last stop bit, the block pops it on that cycle.
// The next start bit then follows with no idle gap.
//
// Build option: defining UART_TX_PARITY_EN adds the PARITY state. That state
// sends the XOR of the data bits for one bit time.
//
// Handshake: fifo_rd_en_o is a combinational pop strobe. The FIFO consumes its
// head word on every rising edge where fifo_rd_en_o is 1. fifo_data_i is
// captured on that same edge. The strobe is only raised while fifo_empty_i
// is 0, tx_en_i is 1 and rst_ni is 1.
//
// Ports:
//   clk_i         in   clock
//   rst_ni        in   synchronous active-low reset
//   tx_en_i       in   allows new frames to start; a frame already running
//                      always completes
//   fifo_empty_i  in   FIFO empty flag
//   fifo_data_i   in   FIFO head word (show-ahead)
//   fifo_rd_en_o  out  pop strobe
//   tx_o          out  serial line, high when idle
//   busy_o        out  high while a frame is on the line
//   dbg_state_o   out  current FSM state, for debug
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_en_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_en_o,
  output logic              tx_o,
  output logic              busy_o,
  output uart_tx_state_e    dbg_state_o
);

  localparam int unsigned       BIDX_W    = $clog2(DATA_W);
  localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(DATA_W - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_e    r_state;
  uart_tx_state_e    w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [BIDX_W-1:0] r_bit_idx;
  logic              r_stop_idx;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  logic w_tick;
  logic w_pop;
  logic w_last_stop;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_pop),
    .tick_o (w_tick)
  );

  // The last cycle of the last stop bit. A pop here chains straight into the
  // next start bit.
  assign w_last_stop = (r_state == ST_STOP) && w_tick && (r_stop_idx == LAST_STOP);

  // rst_ni gates the pop so that nothing leaves the FIFO while reset is held.
  assign w_pop = rst_ni & tx_en_i & ~fifo_empty_i &
                 ((r_state == ST_IDLE) | w_last_stop);

  assign fifo_rd_en_o = w_pop;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_pop)  w_state_nxt = ST_START;
      ST_START: if (w_tick) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_tick && (r_bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_tick) w_state_nxt = ST_STOP;
`endif
      ST_STOP: begin
        if (w_last_stop) w_state_nxt = w_pop ? ST_START : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: the shift register and the bit and stop indices
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (w_pop) begin
      r_shift    <= fifo_data_i;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= ^fifo_data_i;
`endif
    end else if (w_tick) begin
      if (r_state == ST_DATA) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= (r_bit_idx == LAST_BIT) ? '0 : r_bit_idx + BIDX_W'(1);
      end
      if (r_state == ST_STOP) begin
        r_stop_idx <= (r_stop_idx == LAST_STOP) ? 1'b0 : r_stop_idx + 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    tx_o = 1'b1;
    case (r_state)
      ST_START:  tx_o = 1'b0;
      ST_DATA:   tx_o = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_o = r_parity;
`endif
      default:   tx_o = 1'b1;
    endcase
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_tx_drain.sv
module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F1 = CPB * (1 + DW + PB + 1);
  localparam int F2 = CPB * (1 + DW + PB + 2);

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic tx_en  = 1'b0;
  logic tx_en2 = 1'b0;

  // FIFO models (show-ahead, one-cycle write-to-head latency)
  logic          fifo_empty  = 1'b1;
  logic          fifo_empty2 = 1'b1;
  logic [DW-1:0] fifo_data   = '0;
  logic [DW-1:0] fifo_data2  = '0;
  logic          push1 = 1'b0, push2 = 1'b0;
  logic [DW-1:0] pdata1 = '0, pdata2 = '0;
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  int            pop_cyc1[$];
  int            pop_cyc2[$];
  int            pop1 = 0, pop2 = 0, underflow = 0, cyc = 0;

  logic rd_en, rd_en2, tx, tx2, busy, busy2;
  uart_tx_state_e st, st2;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .STOP_BITS(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_en_i(tx_en), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_rd_en_o(rd_en), .tx_o(tx), .busy_o(busy),
    .dbg_state_o(st)
  );

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .STOP_BITS(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .tx_en_i(tx_en2), .fifo_empty_i(fifo_empty2),
    .fifo_data_i(fifo_data2), .fifo_rd_en_o(rd_en2), .tx_o(tx2), .busy_o(busy2),
    .dbg_state_o(st2)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      if (q1.size() == 0) underflow++;
      else begin void'(q1.pop_front()); pop1++; pop_cyc1.push_back(cyc); end
    end
    if (push1) q1.push_back(pdata1);
    fifo_empty <= (q1.size() == 0);
    fifo_data  <= (q1.size() != 0) ? q1[0] : '0;
    if (rd_en2) begin
      if (q2.size() == 0) underflow++;
      else begin void'(q2.pop_front()); pop2++; pop_cyc2.push_back(cyc); end
    end
    if (push2) q2.push_back(pdata2);
    fifo_empty2 <= (q2.size() == 0);
    fifo_data2  <= (q2.size() != 0) ? q2[0] : '0;
    cyc = cyc + 1;
  end

  // Expected line level at cycle k of a frame
  function automatic logic exp_tx(input logic [DW-1:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (PB == 1 && b == DW + 1) return ^d;
    return 1'b1;
  endfunction

  // Driver tasks
  task automatic push_w1(input logic [DW-1:0] d);
    @(negedge clk); push1 = 1'b1; pdata1 = d;
    @(negedge clk); push1 = 1'b0;
  endtask

  task automatic push_w2(input logic [DW-1:0] d);
    @(negedge clk); push2 = 1'b1; pdata2 = d;
    @(negedge clk); push2 = 1'b0;
  endtask

  // Returns at the negedge of frame cycle 0, or with ok=0 after a bounded wait.
  task automatic wait_busy1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_busy2(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else n_pass++;
    n_checks++; if (st !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", st, ST_IDLE); else n_pass++;
    n_checks++; if (tx2 !== 1'b1) $display("FAIL reset_tx2: got %b want 1", tx2); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [10:0] pat;
    int p0;
    bit ok;
`ifdef UART_TX_PARITY_EN
    pat = 11'b10101001010;
`else
    pat = {1'b1, 10'b1101001010};
`endif
    tx_en = 1'b1;
    p0 = pop1;
    push_w1(8'hA5);
    wait_busy1(ok);
    n_checks++; if (!ok) $display("FAIL single_start: busy never rose"); else n_pass++;
    for (int k = 0; k < F1; k++) begin
      n_checks++;
      if (tx !== pat[k/CPB]) $display("FAIL single_tx cyc %0d: got %b want %b", k, tx, pat[k/CPB]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL single_end_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (tx !== 1'b1) $display("FAIL single_end_tx: got %b want 1", tx); else n_pass++;
    n_checks++; if (pop1 - p0 !== 1) $display("FAIL single_pops: got %0d want 1", pop1 - p0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[3];
    int p0, c0, errs, idle_cyc;
    bit ok;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
    tx_en = 1'b0;
    push_w1(words[0]); push_w1(words[1]); push_w1(words[2]);
    repeat (2) @(negedge clk);
    p0 = pop1; c0 = pop_cyc1.size();
    tx_en = 1'b1;
    wait_busy1(ok);
    n_checks++; if (!ok) $display("FAIL b2b_start: busy never rose"); else n_pass++;
    idle_cyc = 0;
    for (int f = 0; f < 3; f++) begin
      errs = 0;
      for (int k = 0; k < F1; k++) begin
        if (tx !== exp_tx(words[f], k)) errs++;
        if (busy !== 1'b1) idle_cyc++;
        @(negedge clk);
      end
      n_checks++; if (errs !== 0) $display("FAIL b2b_frame%0d: %0d bad cycles, want 0", f, errs); else n_pass++;
    end
    n_checks++; if (idle_cyc !== 0) $display("FAIL b2b_gap: %0d idle cycles, want 0", idle_cyc); else n_pass++;
    n_checks++; if (pop1 - p0 !== 3) $display("FAIL b2b_pops: got %0d want 3", pop1 - p0); else n_pass++;
    n_checks++; if (q1.size() !== 0) $display("FAIL b2b_fifo_left: got %0d want 0", q1.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (tx !== 1'b1) $display("FAIL b2b_end_tx: got %b want 1", tx); else n_pass++;
    n_checks++;
    if (pop_cyc1.size() < c0 + 3) $display("FAIL b2b_spacing: got %0d pop records want %0d", pop_cyc1.size() - c0, 3);
    else if (pop_cyc1[c0+1] - pop_cyc1[c0] !== F1 || pop_cyc1[c0+2] - pop_cyc1[c0+1] !== F1)
      $display("FAIL b2b_spacing: got %0d,%0d want %0d", pop_cyc1[c0+1] - pop_cyc1[c0],
               pop_cyc1[c0+2] - pop_cyc1[c0+1], F1);
    else n_pass++;
  endtask

  task automatic test_tx_en_drop();
    int p0, k;
    bit ok;
    tx_en = 1'b0;
    push_w1(8'h5A); push_w1(8'hC3);
    @(negedge clk);
    p0 = pop1;
    tx_en = 1'b1;
    wait_busy1(ok);
    n_checks++; if (!ok) $display("FAIL en_drop_start: busy never rose"); else n_pass++;
    repeat (9) @(negedge clk);
    tx_en = 1'b0;
    k = 9;
    while (busy && k < F1 + 10) begin @(negedge clk); k++; end
    n_checks++; if (k !== F1) $display("FAIL en_drop_frame_len: got %0d want %0d", k, F1); else n_pass++;
    repeat (2 * F1) @(negedge clk);
    n_checks++; if (pop1 - p0 !== 1) $display("FAIL en_drop_pops: got %0d want 1", pop1 - p0); else n_pass++;
    n_checks++; if (q1.size() !== 1) $display("FAIL en_drop_fifo_left: got %0d want 1", q1.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL en_drop_idle: got %b want 0", busy); else n_pass++;
    tx_en = 1'b1;
    repeat (F1 + 6) @(negedge clk);
    n_checks++; if (q1.size() !== 0) $display("FAIL en_drop_drain: got %0d want 0", q1.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p0, qs;
    bit ok;
    tx_en = 1'b0;
    push_w1(8'h96); push_w1(8'h69);
    @(negedge clk);
    tx_en = 1'b1;
    wait_busy1(ok);
    n_checks++; if (!ok) $display("FAIL rst_mid_start: busy never rose"); else n_pass++;
    // Frame cycle 17 is inside data bit 3.
    repeat (17) @(negedge clk);
    n_checks++; if (st !== ST_DATA) $display("FAIL rst_mid_in_data: got %0d want %0d", st, ST_DATA); else n_pass++;
    p0 = pop1; qs = q1.size();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("FAIL rst_mid_tx: got %b want 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL rst_mid_rd_en: got %b want 0", rd_en); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (rd_en !== 1'b0) $display("FAIL rst_hold_rd_en: got %b want 0", rd_en); else n_pass++;
    n_checks++; if (pop1 !== p0) $display("FAIL rst_mid_pops: got %0d want %0d", pop1, p0); else n_pass++;
    n_checks++; if (q1.size() !== 1) $display("FAIL rst_mid_fifo: got %0d want 1 (was %0d)", q1.size(), qs); else n_pass++;
    rst_n = 1'b1;
    repeat (F1 + 6) @(negedge clk);
    n_checks++; if (q1.size() !== 0) $display("FAIL rst_mid_drain: got %0d want 0", q1.size()); else n_pass++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] words[2];
    logic          want_par[2];
    logic          par;
    int            k;
    bit            ok;
    words[0] = 8'hA5; want_par[0] = 1'b0;
    words[1] = 8'h07; want_par[1] = 1'b1;
    tx_en = 1'b1;
    for (int w = 0; w < 2; w++) begin
      push_w1(words[w]);
      wait_busy1(ok);
      n_checks++; if (!ok) $display("FAIL parity_start%0d: busy never rose", w); else n_pass++;
      k = 0; par = 1'bx;
      while (busy && k < 60) begin
        if (k == CPB * (DW + 1) + 1) par = tx;
        @(negedge clk); k++;
      end
      n_checks++; if (par !== want_par[w]) $display("FAIL parity_bit%0d: got %b want %b", w, par, want_par[w]); else n_pass++;
      n_checks++; if (k !== 44) $display("FAIL parity_frame_len%0d: got %0d want 44", w, k); else n_pass++;
    end
  endtask
`endif

  task automatic test_stop2();
    logic [DW-1:0] words[2];
    int c0, errs, stop_hi;
    bit ok;
    words[0] = 8'h81; words[1] = 8'h7E;
    tx_en2 = 1'b0;
    push_w2(words[0]); push_w2(words[1]);
    @(negedge clk);
    c0 = pop_cyc2.size();
    tx_en2 = 1'b1;
    wait_busy2(ok);
    n_checks++; if (!ok) $display("FAIL stop2_start: busy never rose"); else n_pass++;
    stop_hi = 0;
    for (int f = 0; f < 2; f++) begin
      errs = 0;
      for (int k = 0; k < F2; k++) begin
        if (tx2 !== exp_tx(words[f], k) || busy2 !== 1'b1) errs++;
        if (f == 0 && k >= CPB * (1 + DW + PB) && tx2 === 1'b1) stop_hi++;
        @(negedge clk);
      end
      n_checks++; if (errs !== 0) $display("FAIL stop2_frame%0d: %0d bad cycles, want 0", f, errs); else n_pass++;
    end
    n_checks++; if (stop_hi !== 8) $display("FAIL stop2_high_time: got %0d want 8", stop_hi); else n_pass++;
    n_checks++; if (busy2 !== 1'b0) $display("FAIL stop2_end_busy: got %b want 0", busy2); else n_pass++;
    n_checks++;
    if (pop_cyc2.size() < c0 + 2) $display("FAIL stop2_spacing: got %0d pops want 2", pop_cyc2.size() - c0);
    else if (pop_cyc2[c0+1] - pop_cyc2[c0] !== F2)
      $display("FAIL stop2_spacing: got %0d want %0d", pop_cyc2[c0+1] - pop_cyc2[c0], F2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tx_en_drop();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_stop2();
    n_checks++; if (underflow !== 0) $display("FAIL pop_while_empty: got %0d want 0", underflow); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial transmitter that sits directly downstream of the team's show-ahead FIFO and drains it one word at a time onto an asynchronous serial line. It pops a word whenever the FIFO is non-empty and the line is free, then frames it as start bit, DATA_W data bits LSB-first, optional parity and STOP_BITS stop bits. Back-to-back words go out with no idle gap between frames. Typical use is a debug/console UART fed by a producer that writes into the FIFO at bursty rates.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal values ≥ 2.
- DATA_W, default 8: data bits per frame; must equal the FIFO WIDTH; legal range 5–9.
- STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- clk_i  input  1  single clock; all logic on its rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- tx_en_i  input  1  permits starting new frames; never aborts a frame in flight.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_data_i  input  DATA_W  FIFO head word; valid whenever fifo_empty_i is 0 (show-ahead).
- fifo_rd_en_o  output  1  pop strobe to the FIFO; a word is consumed on each clk_i edge where this is 1.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
- Counters:
  - bit-time counter, 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - bit index, 0..DATA_W-1.
  - stop index, 0..STOP_BITS-1.
- Pop condition (combinational): fifo_rd_en_o = tx_en_i & ~fifo_empty_i & (state==IDLE | last cycle of last stop bit).
- On a pop edge:
  - fifo_data_i is captured into the shift register.
  - The bit-time counter clears and the state becomes START.
- START drives tx_o=0 for CLKS_PER_BIT cycles, then goes to DATA.
- DATA drives shift[0], shifting right every CLKS_PER_BIT cycles. After DATA_W bits it goes to PARITY, or to STOP if parity is compiled out.
- STOP drives tx_o=1 for STOP_BITS×CLKS_PER_BIT cycles. On its final cycle it goes to START if the pop condition holds, otherwise to IDLE.
- busy_o = (state != IDLE).
- fifo_rd_en_o is never asserted while fifo_empty_i=1.
- There is never more than one pop per frame.

## Timing
- Reset values: state=IDLE, tx_o=1, busy_o=0, fifo_rd_en_o=0 (forced low while rst_ni=0), all counters 0.
- Latency: if the pop edge ends cycle N, the start bit begins in cycle N+1, and busy_o=1 from cycle N+1.
- Frame length F = CLKS_PER_BIT × (1 + DATA_W + P + STOP_BITS), where P = 1 with parity, else 0.
- Back-to-back words: the next start bit follows the last stop cycle immediately, so frames start every F cycles.
- Edge cases:
  - Empty FIFO at end of frame: go to IDLE with tx_o=1. The next pop happens the first IDLE cycle the FIFO is non-empty.
  - tx_en_i falls mid-frame: the frame completes, then the block stays in IDLE.
  - Reset mid-frame: tx_o=1 from the next edge, the partially sent word is dropped, and the FIFO is not popped again for it.
  - Simultaneous FIFO write-and-tunnel when the FIFO is empty: the head still reads as empty, so no pop occurs that cycle.

## Configuration
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state is added; it transmits the even parity bit (XOR of the data bits) for one bit time.
- Undefined: no PARITY state, and DATA goes directly to STOP.

## Structure
- Package uart_pkg holds:
  - the state enum (uart_tx_state_e);
  - the local constant for the bit-time counter width;
  - a frame-length helper function shared with a future receiver.
- One sub-module, uart_baud_tick: a free-running bit-time counter with a synchronous clear input (cleared on pop) and a one-cycle tick output at count CLKS_PER_BIT-1. The state machine advances only on that tick.

## Test plan
- CLKS_PER_BIT=4, DATA_W=8, no parity; push 0xA5 into an empty FIFO with tx_en_i=1:
  - expect one fifo_rd_en_o pulse;
  - tx_o reads 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles;
  - the frame lasts 40 cycles, then busy_o=0.
- Pre-load 0x00, 0xFF, 0x3C: three pops spaced exactly 40 cycles apart, no idle cycle between the stop and start bits, the FIFO empty afterwards, and tx_o=1.
- UART_TX_PARITY_EN defined: 0xA5 gives parity bit 0 and 0x07 gives parity bit 1; the frame is 44 cycles.
- Drop tx_en_i in the 10th cycle of a frame with two words queued: the current frame completes, no further pop occurs, and one word remains in the FIFO.
- Pull rst_ni low during DATA bit 3: tx_o=1, busy_o=0 and fifo_rd_en_o=0 on the next edge, and the FIFO count is unchanged by the reset.
- STOP_BITS=2: the stop high time is 8 cycles and back-to-back frames are 44 cycles apart.
